elevator_floor_ctrl: RTL and testbench

Request/position controller that sits directly upstream of elevator_fsm. It captures the target floor from the request FIFO whenever the FSM pops it, and tracks the car's current floor with a per-floor travel counter. It compares target against current floor to drive the FSM's move_up/move_down/equal inputs, and runs the door-open timer that produces the FSM's counter_done input.

---
 rtl/elevator_floor_ctrl_if.sv | 54 +++++
 rtl/elevator_floor_ctrl.sv | 106 ++++++++++
 tb/tb_elevator_floor_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/elevator_floor_ctrl_if.sv
// Request/position bundle between the FIFO/FSM side and the floor controller.
// The slave modport is the controller; the master modport drives it.
interface elevator_floor_ctrl_if #(
    parameter int FLOOR_W = 4
);
    logic               i_fifo_ctrl_rd_en;
    logic [FLOOR_W-1:0] i_fifo_ctrl_data;
    logic               i_fsm_ctrl_move_up;
    logic               i_fsm_ctrl_move_down;
    logic               i_fsm_ctrl_open_door;
    logic               i_fsm_ctrl_alarm;
    logic               o_ctrl_fsm_move_up;
    logic               o_ctrl_fsm_move_down;
    logic               o_ctrl_fsm_equal;
    logic               o_counter_fsm_done;
    logic [FLOOR_W-1:0] o_ctrl_current_floor;
    logic [FLOOR_W-1:0] o_ctrl_target_floor;
    logic               o_ctrl_target_valid;
    logic               o_ctrl_req_error;

    modport slave (
        input  i_fifo_ctrl_rd_en,
        input  i_fifo_ctrl_data,
        input  i_fsm_ctrl_move_up,
        input  i_fsm_ctrl_move_down,
        input  i_fsm_ctrl_open_door,
        input  i_fsm_ctrl_alarm,
        output o_ctrl_fsm_move_up,
        output o_ctrl_fsm_move_down,
        output o_ctrl_fsm_equal,
        output o_counter_fsm_done,
        output o_ctrl_current_floor,
        output o_ctrl_target_floor,
        output o_ctrl_target_valid,
        output o_ctrl_req_error
    );

    modport master (
        output i_fifo_ctrl_rd_en,
        output i_fifo_ctrl_data,
        output i_fsm_ctrl_move_up,
        output i_fsm_ctrl_move_down,
        output i_fsm_ctrl_open_door,
        output i_fsm_ctrl_alarm,
        input  o_ctrl_fsm_move_up,
        input  o_ctrl_fsm_move_down,
        input  o_ctrl_fsm_equal,
        input  o_counter_fsm_done,
        input  o_ctrl_current_floor,
        input  o_ctrl_target_floor,
        input  o_ctrl_target_valid,
        input  o_ctrl_req_error
    );
endinterface

// File: rtl/elevator_floor_ctrl.sv
// Elevator floor controller: captures target floors from the request FIFO,
// tracks the car position and runs the door-open timer for the FSM.
module elevator_floor_ctrl #(
    parameter int FLOOR_W       = 4,
    parameter int NUM_FLOORS    = 10,
    parameter int TRAVEL_CYCLES = 8,
    parameter int DOOR_CYCLES   = 16
) (
    input logic                 i_ctrl_clock,
    input logic                 i_ctrl_reset,
    elevator_floor_ctrl_if.slave ctrl
);
    localparam int TW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
    localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [TW-1:0]      TRAVEL_LAST = TW'(TRAVEL_CYCLES - 1);
    localparam logic [DW-1:0]      DOOR_LAST   = DW'(DOOR_CYCLES - 1);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(NUM_FLOORS - 1);
    localparam logic [FLOOR_W:0]   NUM_F       = (FLOOR_W + 1)'(NUM_FLOORS);

    logic [FLOOR_W-1:0] cur_q;
    logic [FLOOR_W-1:0] tgt_q;
    logic               valid_q;
    logic               pend_q;
    logic               err_q;
    logic [TW-1:0]      tcnt_q;
    logic [DW-1:0]      dcnt_q;

    logic in_range;
    logic done;
    logic served;
    logic alarm;
    logic up;
    logic dn;

    assign alarm    = ctrl.i_fsm_ctrl_alarm;
    assign up       = ctrl.i_fsm_ctrl_move_up;
    assign dn       = ctrl.i_fsm_ctrl_move_down;
    assign in_range = {1'b0, ctrl.i_fifo_ctrl_data} < NUM_F;
    assign done     = (dcnt_q == DOOR_LAST);
    // Request is retired only on an edge where the timer actually advances.
    assign served   = done & ~alarm;

    assign ctrl.o_ctrl_fsm_move_up   = valid_q & (tgt_q > cur_q);
    assign ctrl.o_ctrl_fsm_move_down = valid_q & (tgt_q < cur_q);
    assign ctrl.o_ctrl_fsm_equal     = valid_q & (tgt_q == cur_q);
    assign ctrl.o_counter_fsm_done   = done;
    assign ctrl.o_ctrl_current_floor = cur_q;
    assign ctrl.o_ctrl_target_floor  = tgt_q;
    assign ctrl.o_ctrl_target_valid  = valid_q;
    assign ctrl.o_ctrl_req_error     = err_q;

    // Request capture: sample FIFO data the cycle after a pop; capture beats serve.
    always_ff @(posedge i_ctrl_clock) begin
        if (i_ctrl_reset) begin
            pend_q  <= 1'b0;
            err_q   <= 1'b0;
            tgt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            pend_q <= ctrl.i_fifo_ctrl_rd_en;
            err_q  <= pend_q & ~in_range;
            if (pend_q && in_range) begin
                tgt_q   <= ctrl.i_fifo_ctrl_data;
                valid_q <= 1'b1;
            end else if (served) begin
                valid_q <= 1'b0;
            end
        end
    end

    // Travel counter and current floor; alarm freezes so travel resumes mid-floor.
    always_ff @(posedge i_ctrl_clock) begin
        if (i_ctrl_reset) begin
            tcnt_q <= '0;
            cur_q  <= '0;
        end else if (!alarm) begin
            if (up ^ dn) begin
                if (tcnt_q == TRAVEL_LAST) begin
                    tcnt_q <= '0;
                    if (up && cur_q < TOP_FLOOR) begin
                        cur_q <= cur_q + 1'b1;
                    end else if (dn && cur_q != '0) begin
                        cur_q <= cur_q - 1'b1;
                    end
                end else begin
                    tcnt_q <= tcnt_q + 1'b1;
                end
            end else if (!up && !dn) begin
                tcnt_q <= '0;
            end
        end
    end

    // Door-open timer; wraps to zero on the done edge.
    always_ff @(posedge i_ctrl_clock) begin
        if (i_ctrl_reset) begin
            dcnt_q <= '0;
        end else if (!alarm) begin
            if (!ctrl.i_fsm_ctrl_open_door || done) begin
                dcnt_q <= '0;
            end else begin
                dcnt_q <= dcnt_q + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_elevator_floor_ctrl.sv
// Bench for elevator_floor_ctrl: directed scenarios plus random traffic,
// checked every cycle against a behavioural model through a scoreboard queue.
module tb_elevator_floor_ctrl;
    localparam int FLOOR_W       = 4;
    localparam int NUM_FLOORS    = 10;
    localparam int TRAVEL_CYCLES = 8;
    localparam int DOOR_CYCLES   = 16;

    typedef struct {
        int up;
        int dn;
        int eq;
        int done;
        int cur;
        int tgt;
        int valid;
        int err;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t exp_q[$];

    // model state
    int m_cur, m_tgt, m_valid, m_pend, m_err, m_tcnt, m_dcnt;

    elevator_floor_ctrl_if #(.FLOOR_W(FLOOR_W)) bus ();

    elevator_floor_ctrl #(
        .FLOOR_W      (FLOOR_W),
        .NUM_FLOORS   (NUM_FLOORS),
        .TRAVEL_CYCLES(TRAVEL_CYCLES),
        .DOOR_CYCLES  (DOOR_CYCLES)
    ) dut (
        .i_ctrl_clock(clk),
        .i_ctrl_reset(rst),
        .ctrl        (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.up    = (m_valid != 0 && m_tgt > m_cur) ? 1 : 0;
        e.dn    = (m_valid != 0 && m_tgt < m_cur) ? 1 : 0;
        e.eq    = (m_valid != 0 && m_tgt == m_cur) ? 1 : 0;
        e.done  = (m_dcnt == DOOR_CYCLES - 1) ? 1 : 0;
        e.cur   = m_cur;
        e.tgt   = m_tgt;
        e.valid = m_valid;
        e.err   = m_err;
        return e;
    endfunction

    task automatic model_adv(input bit rd, input int data, input bit up,
                             input bit dn, input bit open, input bit alarm,
                             input bit r);
        int n_valid;
        if (r) begin
            m_cur = 0; m_tgt = 0; m_valid = 0; m_pend = 0;
            m_err = 0; m_tcnt = 0; m_dcnt = 0;
            return;
        end
        n_valid = m_valid;
        if (m_dcnt == DOOR_CYCLES - 1 && !alarm) n_valid = 0;
        m_err = (m_pend != 0 && data >= NUM_FLOORS) ? 1 : 0;
        if (m_pend != 0 && data < NUM_FLOORS) begin
            m_tgt   = data;
            n_valid = 1;
        end
        m_valid = n_valid;
        m_pend  = rd ? 1 : 0;
        if (!alarm) begin
            if (up != dn) begin
                m_tcnt++;
                if (m_tcnt == TRAVEL_CYCLES) begin
                    m_tcnt = 0;
                    if (up) m_cur = (m_cur + 1 > NUM_FLOORS - 1) ? NUM_FLOORS - 1 : m_cur + 1;
                    else    m_cur = (m_cur == 0) ? 0 : m_cur - 1;
                end
            end else if (!up) begin
                m_tcnt = 0;
            end
            m_dcnt = open ? (m_dcnt + 1) % DOOR_CYCLES : 0;
        end
    endtask

    task automatic step(input bit rd, input int data, input bit up,
                        input bit dn, input bit open, input bit alarm,
                        input bit r);
        @(posedge clk);
        #1;
        exp_q.push_back(model_out());
        bus.i_fifo_ctrl_rd_en    = rd;
        bus.i_fifo_ctrl_data     = FLOOR_W'(data);
        bus.i_fsm_ctrl_move_up   = up;
        bus.i_fsm_ctrl_move_down = dn;
        bus.i_fsm_ctrl_open_door = open;
        bus.i_fsm_ctrl_alarm     = alarm;
        rst                      = r;
        model_adv(rd, data, up, dn, open, alarm, r);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: compare every presented cycle against the scoreboard head.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("move_up", int'(bus.o_ctrl_fsm_move_up), e.up);
            chk("move_down", int'(bus.o_ctrl_fsm_move_down), e.dn);
            chk("equal", int'(bus.o_ctrl_fsm_equal), e.eq);
            chk("done", int'(bus.o_counter_fsm_done), e.done);
            chk("current", int'(bus.o_ctrl_current_floor), e.cur);
            chk("target", int'(bus.o_ctrl_target_floor), e.tgt);
            chk("valid", int'(bus.o_ctrl_target_valid), e.valid);
            chk("req_error", int'(bus.o_ctrl_req_error), e.err);
        end
    end

    initial begin
        bit rd, up, dn, open, al, r;
        int data;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.i_fifo_ctrl_rd_en    = 1'b0;
        bus.i_fifo_ctrl_data     = '0;
        bus.i_fsm_ctrl_move_up   = 1'b0;
        bus.i_fsm_ctrl_move_down = 1'b0;
        bus.i_fsm_ctrl_open_door = 1'b0;
        bus.i_fsm_ctrl_alarm     = 1'b0;
        repeat (2) @(posedge clk);
        model_adv(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        idle(1);

        // request floor 3, travel up
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 3, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3 * TRAVEL_CYCLES; i++) step(0, 0, 1, 0, 0, 0, 0);
        idle(1);
        chk("plan1_cur", int'(bus.o_ctrl_current_floor), 3);
        chk("plan1_equal", int'(bus.o_ctrl_fsm_equal), 1);

        // request floor 1, travel down, serve with the door
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2 * TRAVEL_CYCLES; i++) step(0, 0, 0, 1, 0, 0, 0);
        idle(1);
        chk("plan2_cur", int'(bus.o_ctrl_current_floor), 1);
        for (int i = 0; i < DOOR_CYCLES; i++) step(0, 0, 0, 0, 1, 0, 0);
        idle(1);
        chk("plan2_served", int'(bus.o_ctrl_target_valid), 0);

        // out-of-range request
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 12, 0, 0, 0, 0, 0);
        idle(3);

        // alarm freeze mid-floor
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 5, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0, 0, 0);
        idle(1);
        chk("plan4_cur", int'(bus.o_ctrl_current_floor), 2);

        // door with alarm pause, capture on the done edge
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 1, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 1, 0, 0);
        step(0, 7, 0, 0, 1, 0, 0);
        idle(1);
        chk("plan5_valid", int'(bus.o_ctrl_target_valid), 1);
        chk("plan5_target", int'(bus.o_ctrl_target_floor), 7);

        // reset while moving with the door counter running
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 1, 0, 0);
        step(0, 0, 1, 0, 1, 0, 1);
        idle(1);
        chk("plan6_valid", int'(bus.o_ctrl_target_valid), 0);

        // random traffic, FSM-like moves with occasional illegal combos
        al = 0;
        for (int i = 0; i < 3000; i++) begin
            exp_t e;
            e    = model_out();
            r    = ($urandom % 300) == 0;
            rd   = ($urandom % 10) == 0;
            data = int'($urandom_range(0, 15));
            if (($urandom % 25) == 0) al = ~al;
            if (($urandom % 16) == 0) begin
                up = 1'($urandom);
                dn = 1'($urandom);
            end else begin
                up = e.up[0];
                dn = e.dn[0];
            end
            open = e.eq[0] && (($urandom % 8) != 0);
            step(rd, data, up, dn, open, al, r);
        end

        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
